// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with fetch handshake, stall hold buffer and flush.
module if_id_stage #(
   parameter int                 DATA_W    = 32,
   parameter logic [DATA_W-1:0]  NOP_INSTR = '0
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic [DATA_W-1:0] PC_F,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              imem_ready,
   input  logic              StallD,
   input  logic              FlushD,
   output logic              imem_req,
   output logic              PCEnable,
   output logic [DATA_W-1:0] InstrD,
   output logic [DATA_W-1:0] PCD,
   output logic [DATA_W-1:0] PCPlus4D,
   output logic              ValidD
);
   logic [DATA_W-1:0] r_instr, r_pc, r_pc4, r_hold_instr, r_hold_pc;
   logic              r_valid, r_hold_valid;
   logic              w_fetch_done;
   assign imem_req     = ~reset & ~r_hold_valid;
   assign PCEnable     = ~reset & (FlushD | (imem_ready & ~r_hold_valid));
   assign w_fetch_done = imem_ready & imem_req;
   assign InstrD       = r_instr;
   assign PCD          = r_pc;
   assign PCPlus4D     = r_pc4;
   assign ValidD       = r_valid;
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_instr      <= NOP_INSTR;
         r_pc         <= '0;
         r_pc4        <= '0;
         r_valid      <= 1'b0;
         r_hold_valid <= 1'b0;
      end else if (FlushD) begin
         r_instr      <= NOP_INSTR;
         r_valid      <= 1'b0;
         r_hold_valid <= 1'b0;
      end else if (!StallD) begin
         r_hold_valid <= 1'b0;
         if (r_hold_valid) begin
            r_instr <= r_hold_instr;
            r_pc    <= r_hold_pc;
            r_pc4   <= r_hold_pc + DATA_W'(4);
            r_valid <= 1'b1;
         end else if (w_fetch_done) begin
            r_instr <= imem_rdata;
            r_pc    <= PC_F;
            r_pc4   <= PC_F + DATA_W'(4);
            r_valid <= 1'b1;
         end else begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
         end
      end else if (w_fetch_done) begin
         // decode is stalled, so park the returning word instead of dropping it
         r_hold_instr <= imem_rdata;
         r_hold_pc    <= PC_F;
         r_hold_valid <= 1'b1;
      end
   end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed checks of reset, streaming, stall/hold, flush, memory wait and PC wrap.
module tb_if_id_stage;
   logic        CLK = 1'b0;
   logic        reset, imem_ready, StallD, FlushD;
   logic [31:0] PC_F, imem_rdata;
   logic        imem_req, PCEnable, ValidD;
   logic [31:0] InstrD, PCD, PCPlus4D;
   int          checks = 0;
   int          errors = 0;
   localparam logic [31:0] A = 32'h20080005, B = 32'h2009000A, C = 32'h01095020;
   localparam logic [31:0] DW = 32'hAC0A0000, E = 32'h8C0B0004, X = 32'hDEADBEEF;
   if_id_stage dut (
      .CLK(CLK), .reset(reset), .PC_F(PC_F), .imem_rdata(imem_rdata),
      .imem_ready(imem_ready), .StallD(StallD), .FlushD(FlushD),
      .imem_req(imem_req), .PCEnable(PCEnable), .InstrD(InstrD),
      .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
   );
   always #5 CLK = ~CLK;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic chk_d(input string tag, input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] p4, input logic v);
      chk({tag, "_instr"}, InstrD, i);
      chk({tag, "_pc"}, PCD, p);
      chk({tag, "_pc4"}, PCPlus4D, p4);
      chk({tag, "_valid"}, {31'b0, ValidD}, {31'b0, v});
   endtask
   initial begin
      reset = 1'b1; imem_ready = 1'b1; imem_rdata = A; PC_F = 32'd0; StallD = 1'b0; FlushD = 1'b0;
      tick();
      tick();
      chk_d("rst", 32'd0, 32'd0, 32'd0, 1'b0);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_pcen", {31'b0, PCEnable}, 32'd0);
      reset = 1'b0; #1;
      chk("run_req", {31'b0, imem_req}, 32'd1);
      chk("run_pcen", {31'b0, PCEnable}, 32'd1);
      tick();
      chk_d("s0", A, 32'd0, 32'd4, 1'b1);
      PC_F = 32'd4; imem_rdata = B;
      tick();
      chk_d("s1", B, 32'd4, 32'd8, 1'b1);
      PC_F = 32'd8; imem_rdata = C;
      tick();
      chk_d("s2", C, 32'd8, 32'd12, 1'b1);
      reset = 1'b1;
      tick();
      chk_d("rst2", 32'd0, 32'd0, 32'd0, 1'b0);
      reset = 1'b0; PC_F = 32'd0; imem_rdata = A;
      tick();
      chk_d("pre_stall", A, 32'd0, 32'd4, 1'b1);
      StallD = 1'b1; PC_F = 32'd4; imem_rdata = B; #1;
      chk("stall1_pcen", {31'b0, PCEnable}, 32'd1);
      tick();
      chk_d("stall1", A, 32'd0, 32'd4, 1'b1);
      PC_F = 32'd8; imem_rdata = X; #1;
      chk("hold_req", {31'b0, imem_req}, 32'd0);
      chk("hold_pcen", {31'b0, PCEnable}, 32'd0);
      tick();
      chk_d("stall2", A, 32'd0, 32'd4, 1'b1);
      chk("stall2_pcen", {31'b0, PCEnable}, 32'd0);
      tick();
      chk_d("stall3", A, 32'd0, 32'd4, 1'b1);
      StallD = 1'b0; #1;
      chk("drain_pcen", {31'b0, PCEnable}, 32'd0);
      tick();
      chk_d("drain", B, 32'd4, 32'd8, 1'b1);
      chk("drain_req", {31'b0, imem_req}, 32'd1);
      imem_rdata = C;
      tick();
      chk_d("post_drain", C, 32'd8, 32'd12, 1'b1);
      StallD = 1'b1; PC_F = 32'd12; imem_rdata = X;
      tick();
      chk("fill_req", {31'b0, imem_req}, 32'd0);
      FlushD = 1'b1; PC_F = 32'd16; #1;
      chk("flush_pcen", {31'b0, PCEnable}, 32'd1);
      tick();
      chk_d("flush", 32'd0, 32'd8, 32'd12, 1'b0);
      FlushD = 1'b0; StallD = 1'b0; imem_ready = 1'b0; #1;
      chk("flush_req", {31'b0, imem_req}, 32'd1);
      chk("wait_pcen", {31'b0, PCEnable}, 32'd0);
      tick();
      chk("wait1_valid", {31'b0, ValidD}, 32'd0);
      chk("wait1_instr", InstrD, 32'd0);
      tick();
      chk("wait2_valid", {31'b0, ValidD}, 32'd0);
      chk("wait2_pcen", {31'b0, PCEnable}, 32'd0);
      imem_ready = 1'b1; imem_rdata = DW;
      tick();
      chk_d("wait_done", DW, 32'd16, 32'd20, 1'b1);
      PC_F = 32'hFFFFFFFC; imem_rdata = E;
      tick();
      chk_d("wrap", E, 32'hFFFFFFFC, 32'd0, 1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
